// File: rtl/k_and_s_pkg.sv
// Shared types and encodings for the K&S datapath: decoded instruction set,
// opcode values, ALU operation codes and the flags bundle.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP, I_BRANCH, I_BZERO, I_BNEG, I_BNNEG, I_BNZERO, I_LOAD,
    I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_HALT
  } decoded_instruction_type;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_BRANCH = 8'h01;
  localparam logic [7:0] OP_BZERO  = 8'h02;
  localparam logic [7:0] OP_BNEG   = 8'h03;
  localparam logic [7:0] OP_BNNEG  = 8'h0A;
  localparam logic [7:0] OP_BNZERO = 8'h0B;
  localparam logic [7:0] OP_LOAD   = 8'h81;
  localparam logic [7:0] OP_STORE  = 8'h82;
  localparam logic [7:0] OP_MOVE   = 8'h91;
  localparam logic [7:0] OP_ADD    = 8'hA1;
  localparam logic [7:0] OP_SUB    = 8'hA2;
  localparam logic [7:0] OP_AND    = 8'hA3;
  localparam logic [7:0] OP_OR     = 8'hA4;
  localparam logic [7:0] OP_HALT   = 8'hFF;

  localparam logic [1:0] ALU_OR  = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

  typedef struct packed {
    logic zero;
    logic neg;
    logic unsigned_ovf;
    logic signed_ovf;
  } flags_t;

  // Unlisted opcodes fall back to NOP so the control unit never sees garbage.
  function automatic decoded_instruction_type decode_opcode(input logic [7:0] op);
    case (op)
      OP_NOP:    return I_NOP;
      OP_BRANCH: return I_BRANCH;
      OP_BZERO:  return I_BZERO;
      OP_BNEG:   return I_BNEG;
      OP_BNNEG:  return I_BNNEG;
      OP_BNZERO: return I_BNZERO;
      OP_LOAD:   return I_LOAD;
      OP_STORE:  return I_STORE;
      OP_MOVE:   return I_MOVE;
      OP_ADD:    return I_ADD;
      OP_SUB:    return I_SUB;
      OP_AND:    return I_AND;
      OP_OR:     return I_OR;
      OP_HALT:   return I_HALT;
      default:   return I_NOP;
    endcase
  endfunction

endpackage

// File: rtl/ks_data_path_p_if.sv
// Control-unit / RAM side bundle of the K&S datapath.
interface ks_data_path_p_if
  import k_and_s_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5
);
  logic                    branch;
  logic                    pc_enable;
  logic                    ir_enable;
  logic                    addr_sel;
  logic                    c_sel;
  logic [1:0]              operation;
  logic                    write_reg_enable;
  logic                    flags_reg_enable;
  logic [DATA_W-1:0]       data_in;
  decoded_instruction_type decoded_instruction;
  logic                    zero_op;
  logic                    neg_op;
  logic                    unsigned_overflow;
  logic                    signed_overflow;
  logic [ADDR_W-1:0]       ram_addr;
  logic [DATA_W-1:0]       data_out;

  modport master (
    output branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, data_in,
    input  decoded_instruction, zero_op, neg_op, unsigned_overflow,
           signed_overflow, ram_addr, data_out
  );

  modport slave (
    input  branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, data_in,
    output decoded_instruction, zero_op, neg_op, unsigned_overflow,
           signed_overflow, ram_addr, data_out
  );

endinterface

// File: rtl/ks_alu.sv
// Combinational ALU: OR/ADD/SUB/AND with raw zero, negative and overflow flags.
module ks_alu
  import k_and_s_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [1:0]        operation,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output flags_t            flags
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // Extra MSB carries carry-out for ADD and borrow (a < b) for SUB.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result             = '0;
    flags.unsigned_ovf = 1'b0;
    flags.signed_ovf   = 1'b0;
    unique case (operation)
      ALU_OR:  result = a | b;
      ALU_ADD: begin
        result             = sum[DATA_W-1:0];
        flags.unsigned_ovf = sum[DATA_W];
        flags.signed_ovf   = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        result             = diff[DATA_W-1:0];
        flags.unsigned_ovf = diff[DATA_W];
        flags.signed_ovf   = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND: result = a & b;
      default: ;
    endcase
    flags.zero = (result == '0);
    flags.neg  = result[DATA_W-1];
  end

endmodule

// File: rtl/ks_data_path_p.sv
// K&S processor datapath: PC, IR, opcode/field decode, register file, ALU and
// registered flags, sitting between the control unit and the program/data RAM.
module ks_data_path_p
  import k_and_s_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREGS  = 4
) (
  input logic             clk,
  input logic             rst_n,
  ks_data_path_p_if.slave bus
);

  localparam int unsigned RW = $clog2(NREGS);

  logic [DATA_W-1:0]       ir_q;
  logic [ADDR_W-1:0]       pc_q;
  logic [DATA_W-1:0]       regs_q [NREGS];
  flags_t                  flags_q;
  flags_t                  alu_flags;
  decoded_instruction_type instr;
  logic [ADDR_W-1:0]       ir_addr;
  logic [RW-1:0]           sel_a, sel_b, sel_c;
  logic [DATA_W-1:0]       bus_a, bus_b, alu_out, wb_data;
  logic                    unused_ir;

  assign instr   = decode_opcode(ir_q[DATA_W-1 -: 8]);
  assign ir_addr = ir_q[ADDR_W-1:0];
  assign unused_ir = ^ir_q;

  // ALU field layout is the default; memory and move ops relocate their selectors.
  always_comb begin
    sel_a = ir_q[RW-1:0];
    sel_b = ir_q[2*RW-1:RW];
    sel_c = ir_q[3*RW-1:2*RW];
    case (instr)
      I_LOAD:  sel_c = ir_q[ADDR_W+RW-1:ADDR_W];
      I_STORE: sel_a = ir_q[ADDR_W+RW-1:ADDR_W];
      I_MOVE: begin
        sel_b = ir_q[RW-1:0];
        sel_c = ir_q[2*RW-1:RW];
      end
      default: ;
    endcase
  end

  assign bus_a   = regs_q[sel_a];
  assign bus_b   = regs_q[sel_b];
  assign wb_data = bus.c_sel ? bus.data_in : alu_out;

  ks_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .operation (bus.operation),
    .a         (bus_a),
    .b         (bus_b),
    .result    (alu_out),
    .flags     (alu_flags)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir_q    <= '0;
      pc_q    <= '0;
      flags_q <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      if (bus.ir_enable) ir_q <= bus.data_in;
      // Branch target comes from the IR held before this edge.
      if (bus.pc_enable) pc_q <= bus.branch ? ir_addr : pc_q + ADDR_W'(1);
      if (bus.write_reg_enable) regs_q[sel_c] <= wb_data;
      if (bus.flags_reg_enable) flags_q <= alu_flags;
    end
  end

  assign bus.decoded_instruction = instr;
  assign bus.ram_addr            = bus.addr_sel ? ir_addr : pc_q;
  assign bus.data_out            = bus_a;
  assign bus.zero_op             = flags_q.zero;
  assign bus.neg_op              = flags_q.neg;
  assign bus.unsigned_overflow   = flags_q.unsigned_ovf;
  assign bus.signed_overflow     = flags_q.signed_ovf;

endmodule

// File: tb/tb_ks_data_path_p.sv
// Directed bench for ks_data_path_p with DATA_W=16, ADDR_W=5, NREGS=4.
module tb_ks_data_path_p;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ks_data_path_p_if #(.DATA_W(16), .ADDR_W(5)) bus ();

  ks_data_path_p #(
    .DATA_W (16),
    .ADDR_W (5),
    .NREGS  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0]              op_tab  [14] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h0A, 8'h0B, 8'h81,
                                            8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hFF};
  decoded_instruction_type exp_tab [14] = '{I_NOP, I_BRANCH, I_BZERO, I_BNEG, I_BNNEG,
                                            I_BNZERO, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB,
                                            I_AND, I_OR, I_HALT};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.branch = 0; bus.pc_enable = 0; bus.ir_enable = 0; bus.addr_sel = 0;
    bus.c_sel = 0; bus.operation = 2'b00; bus.write_reg_enable = 0;
    bus.flags_reg_enable = 0;
  endtask

  task automatic load_ir(input logic [15:0] v);
    bus.data_in = v; bus.ir_enable = 1; step(); bus.ir_enable = 0;
  endtask

  task automatic write_reg(input int k, input logic [15:0] v);
    load_ir(16'h8100 | 16'(k << 5));
    bus.data_in = v; bus.c_sel = 1; bus.write_reg_enable = 1;
    step();
    bus.write_reg_enable = 0; bus.c_sel = 0;
  endtask

  task automatic read_reg(input int k, output logic [15:0] v);
    load_ir(16'h8200 | 16'(k << 5));
    v = bus.data_out;
  endtask

  task automatic run_alu(input logic [15:0] ir, input logic [1:0] op, input logic fl);
    load_ir(ir);
    bus.operation = op; bus.c_sel = 0; bus.write_reg_enable = 1; bus.flags_reg_enable = fl;
    step();
    bus.write_reg_enable = 0; bus.flags_reg_enable = 0;
  endtask

  function automatic logic [3:0] flags_now();
    return {bus.zero_op, bus.neg_op, bus.unsigned_overflow, bus.signed_overflow};
  endfunction

  task automatic test_reset();
    logic [15:0] v;
    bus.branch = 1; bus.pc_enable = 1; bus.ir_enable = 1; bus.addr_sel = 0; bus.c_sel = 1;
    bus.operation = 2'b01; bus.write_reg_enable = 1; bus.flags_reg_enable = 1;
    bus.data_in = 16'hA1FF;
    rst_n = 0;
    step(); step();
    total++; if (bus.ram_addr !== 5'd0) begin bad++;
      $display("FAIL reset_pc: got %0d want 0", bus.ram_addr); end
    total++; if (flags_now() !== 4'b0000) begin bad++;
      $display("FAIL reset_flags: got %b want 0000", flags_now()); end
    total++; if (bus.decoded_instruction !== I_NOP) begin bad++;
      $display("FAIL reset_decode: got %0d want %0d", bus.decoded_instruction, I_NOP); end
    total++; if (bus.data_out !== 16'h0000) begin bad++;
      $display("FAIL reset_data_out: got %h want 0000", bus.data_out); end
    bus.addr_sel = 1; #1;
    total++; if (bus.ram_addr !== 5'd0) begin bad++;
      $display("FAIL reset_ir_addr: got %0d want 0", bus.ram_addr); end
    idle();
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      read_reg(k, v);
      total++; if (v !== 16'h0000) begin bad++;
        $display("FAIL reset_reg%0d: got %h want 0000", k, v); end
    end
  endtask

  task automatic test_load();
    logic [15:0] v;
    load_ir(16'h8145);
    bus.addr_sel = 1; #1;
    total++; if (bus.ram_addr !== 5'd5) begin bad++;
      $display("FAIL load_addr: got %0d want 5", bus.ram_addr); end
    total++; if (bus.decoded_instruction !== I_LOAD) begin bad++;
      $display("FAIL load_decode: got %0d want %0d", bus.decoded_instruction, I_LOAD); end
    bus.data_in = 16'h1234; bus.c_sel = 1; bus.write_reg_enable = 1;
    step();
    idle();
    read_reg(2, v);
    total++; if (v !== 16'h1234) begin bad++;
      $display("FAIL load_r2: got %h want 1234", v); end
  endtask

  task automatic test_back_to_back();
    // LOAD 0x8142 targets r2 and also selects r2 onto bus A.
    load_ir(16'h8142);
    bus.data_in = 16'h1111; bus.c_sel = 1; bus.write_reg_enable = 1;
    step();
    total++; if (bus.data_out !== 16'h1111) begin bad++;
      $display("FAIL b2b_first: got %h want 1111", bus.data_out); end
    bus.data_in = 16'h2222; #1;
    total++; if (bus.data_out !== 16'h1111) begin bad++;
      $display("FAIL b2b_no_bypass: got %h want 1111", bus.data_out); end
    step();
    idle();
    total++; if (bus.data_out !== 16'h2222) begin bad++;
      $display("FAIL b2b_second: got %h want 2222", bus.data_out); end
  endtask

  task automatic test_add_overflow();
    logic [15:0] v;
    write_reg(0, 16'h7FFF);
    write_reg(1, 16'h0001);
    run_alu(16'hA134, ALU_ADD, 1'b1);
    total++; if (bus.decoded_instruction !== I_ADD) begin bad++;
      $display("FAIL add_decode: got %0d want %0d", bus.decoded_instruction, I_ADD); end
    total++; if (flags_now() !== 4'b0101) begin bad++;
      $display("FAIL add_flags: got %b want 0101", flags_now()); end
    read_reg(3, v);
    total++; if (v !== 16'h8000) begin bad++;
      $display("FAIL add_r3: got %h want 8000", v); end
    write_reg(0, 16'h8000);
    write_reg(1, 16'h8000);
    run_alu(16'hA134, ALU_ADD, 1'b1);
    total++; if (flags_now() !== 4'b1011) begin bad++;
      $display("FAIL add_carry_flags: got %b want 1011", flags_now()); end
  endtask

  task automatic test_logic_ops();
    logic [15:0] v;
    run_alu(16'hA434, ALU_OR, 1'b1);
    total++; if (flags_now() !== 4'b0100) begin bad++;
      $display("FAIL or_flags: got %b want 0100", flags_now()); end
    write_reg(0, 16'hF0F0);
    write_reg(1, 16'h0FF0);
    run_alu(16'hA434, ALU_OR, 1'b1);
    read_reg(3, v);
    total++; if (v !== 16'hFFF0) begin bad++;
      $display("FAIL or_r3: got %h want fff0", v); end
    run_alu(16'hA334, ALU_AND, 1'b1);
    read_reg(3, v);
    total++; if (v !== 16'h00F0) begin bad++;
      $display("FAIL and_r3: got %h want 00f0", v); end
    total++; if (flags_now() !== 4'b0000) begin bad++;
      $display("FAIL and_flags: got %b want 0000", flags_now()); end
  endtask

  task automatic test_sub();
    logic [15:0] v;
    write_reg(0, 16'h0000);
    write_reg(1, 16'h0001);
    run_alu(16'hA234, ALU_SUB, 1'b1);
    total++; if (flags_now() !== 4'b0110) begin bad++;
      $display("FAIL sub_borrow_flags: got %b want 0110", flags_now()); end
    read_reg(3, v);
    total++; if (v !== 16'hFFFF) begin bad++;
      $display("FAIL sub_r3: got %h want ffff", v); end
    write_reg(0, 16'h8000);
    write_reg(1, 16'h0001);
    run_alu(16'hA234, ALU_SUB, 1'b1);
    total++; if (flags_now() !== 4'b0001) begin bad++;
      $display("FAIL sub_signed_flags: got %b want 0001", flags_now()); end
    write_reg(0, 16'h0005);
    write_reg(1, 16'h0005);
    run_alu(16'hA234, ALU_SUB, 1'b1);
    total++; if (flags_now() !== 4'b1000) begin bad++;
      $display("FAIL sub_zero_flags: got %b want 1000", flags_now()); end
  endtask

  task automatic test_move();
    logic [15:0] v;
    write_reg(1, 16'hBEEF);
    write_reg(0, 16'h0000);
    // MOVE r1 -> r0 via OR of r1 with itself.
    load_ir(16'h9101);
    total++; if (bus.data_out !== 16'hBEEF) begin bad++;
      $display("FAIL move_bus_a: got %h want beef", bus.data_out); end
    bus.operation = ALU_OR; bus.write_reg_enable = 1;
    step();
    idle();
    read_reg(0, v);
    total++; if (v !== 16'hBEEF) begin bad++;
      $display("FAIL move_r0: got %h want beef", v); end
  endtask

  task automatic test_unknown_and_hold();
    logic [15:0] v;
    load_ir(16'h5512);
    total++; if (bus.decoded_instruction !== I_NOP) begin bad++;
      $display("FAIL unknown_decode: got %0d want %0d", bus.decoded_instruction, I_NOP); end
    for (int i = 0; i < 14; i++) begin
      load_ir({op_tab[i], 8'h00});
      total++; if (bus.decoded_instruction !== exp_tab[i]) begin bad++;
        $display("FAIL decode_%h: got %0d want %0d", op_tab[i], bus.decoded_instruction,
                 exp_tab[i]); end
    end
    write_reg(0, 16'h7FFF);
    write_reg(1, 16'h0001);
    run_alu(16'hA134, ALU_ADD, 1'b1);
    write_reg(0, 16'h0005);
    write_reg(1, 16'h0005);
    run_alu(16'hA234, ALU_SUB, 1'b0);
    total++; if (flags_now() !== 4'b0101) begin bad++;
      $display("FAIL flags_hold: got %b want 0101", flags_now()); end
    read_reg(3, v);
    total++; if (v !== 16'h0000) begin bad++;
      $display("FAIL hold_r3: got %h want 0000", v); end
  endtask

  task automatic test_pc();
    load_ir(16'h011F);
    bus.pc_enable = 1; bus.branch = 1; step(); idle();
    total++; if (bus.ram_addr !== 5'd31) begin bad++;
      $display("FAIL pc_branch31: got %0d want 31", bus.ram_addr); end
    bus.pc_enable = 1; bus.branch = 0; step(); idle();
    total++; if (bus.ram_addr !== 5'd0) begin bad++;
      $display("FAIL pc_wrap: got %0d want 0", bus.ram_addr); end
    load_ir(16'h0107);
    bus.pc_enable = 1; bus.branch = 1; step(); idle();
    total++; if (bus.ram_addr !== 5'd7) begin bad++;
      $display("FAIL pc_branch7: got %0d want 7", bus.ram_addr); end
    total++; if (bus.decoded_instruction !== I_BRANCH) begin bad++;
      $display("FAIL pc_decode: got %0d want %0d", bus.decoded_instruction, I_BRANCH); end
    // Simultaneous IR load and branch: target must come from the old IR.
    bus.data_in = 16'h0303; bus.ir_enable = 1; bus.pc_enable = 1; bus.branch = 1;
    step(); idle();
    total++; if (bus.ram_addr !== 5'd7) begin bad++;
      $display("FAIL pc_old_ir: got %0d want 7", bus.ram_addr); end
    total++; if (bus.decoded_instruction !== I_BNEG) begin bad++;
      $display("FAIL ir_same_edge: got %0d want %0d", bus.decoded_instruction, I_BNEG); end
    bus.pc_enable = 1; step(); idle();
    total++; if (bus.ram_addr !== 5'd8) begin bad++;
      $display("FAIL pc_incr: got %0d want 8", bus.ram_addr); end
    bus.addr_sel = 1; #1;
    total++; if (bus.ram_addr !== 5'd3) begin bad++;
      $display("FAIL addr_sel_ir: got %0d want 3", bus.ram_addr); end
    idle();
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    write_reg(2, 16'h5A5A);
    load_ir(16'h8140);
    bus.data_in = 16'hAAAA; bus.c_sel = 1; bus.write_reg_enable = 1;
    bus.flags_reg_enable = 1; bus.pc_enable = 1;
    rst_n = 0;
    step();
    rst_n = 1;
    idle();
    total++; if (bus.ram_addr !== 5'd0) begin bad++;
      $display("FAIL mid_reset_pc: got %0d want 0", bus.ram_addr); end
    total++; if (flags_now() !== 4'b0000) begin bad++;
      $display("FAIL mid_reset_flags: got %b want 0000", flags_now()); end
    read_reg(2, v);
    total++; if (v !== 16'h0000) begin bad++;
      $display("FAIL mid_reset_r2: got %h want 0000", v); end
  endtask

  initial begin
    rst_n = 0;
    bus.data_in = '0;
    idle();
    test_reset();
    test_load();
    test_back_to_back();
    test_add_overflow();
    test_logic_ops();
    test_sub();
    test_move();
    test_unknown_and_hold();
    test_pc();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ks_data_path_p.md
# ks_data_path_p

Parametrised successor to the K&S processor datapath, placed between the K&S control unit and the single-port program/data RAM. Holds the program counter, instruction register, opcode decoder, an NREGS-entry register file, the ALU and a registered flags register. Data width, RAM address width and register count are generic. The block adds defined PC increment/branch, unknown-opcode handling and gated flags.

## Interface
Parameters:
- DATA_W, 16: data/instruction width; at least 16.
- ADDR_W, 5: RAM address and PC width; ADDR_W+RW ≤ DATA_W-8.
- NREGS, 4: register count, power of two ≥ 2; RW = $clog2(NREGS); 3·RW ≤ DATA_W-8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- branch  in  1  PC load source: 1 = IR address field, 0 = PC+1.
- pc_enable  in  1  PC update strobe.
- ir_enable  in  1  IR load strobe from data_in.
- addr_sel  in  1  ram_addr source: 0 = PC, 1 = IR address field.
- c_sel  in  1  write-back source: 1 = data_in, 0 = ALU result.
- operation  in  2  ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND.
- write_reg_enable  in  1  register file write strobe.
- flags_reg_enable  in  1  flags register load strobe.
- data_in  in  DATA_W  RAM read data.
- decoded_instruction  out  decoded_instruction_type  decoded IR opcode.
- zero_op, neg_op, unsigned_overflow, signed_overflow  out  1 each  registered flags.
- ram_addr  out  ADDR_W  RAM address.
- data_out  out  DATA_W  RAM write data (register A).

## Operation
- Opcode is IR[DATA_W-1:DATA_W-8]: 0x00 NOP, 0x01 BRANCH, 0x02 BZERO, 0x03 BNEG, 0x0A BNNEG, 0x0B BNZERO, 0x81 LOAD, 0x82 STORE, 0x91 MOVE, 0xA1 ADD, 0xA2 SUB, 0xA3 AND, 0xA4 OR, 0xFF HALT. Any other opcode decodes to I_NOP.
- Address field is IR[ADDR_W-1:0] for all opcodes.
- LOAD: C = IR[ADDR_W+RW-1:ADDR_W]. STORE: A = same field.
- MOVE: A = B = IR[RW-1:0], C = IR[2RW-1:RW].
- ALU ops: A = IR[RW-1:0], B = IR[2RW-1:RW], C = IR[3RW-1:2RW].
- Field decode is purely combinational from IR; unused fields are don't-care but never latch.
- bus_a = reg[A], bus_b = reg[B], data_out = bus_a.
- Write-back: if write_reg_enable, reg[C] ← c_sel ? data_in : alu_out. Register 0 is not hardwired.
- ALU arithmetic is modulo 2^DATA_W.
- Flags:
  - zero = (result == 0); neg = result[DATA_W-1].
  - ADD: unsigned = carry-out; signed = operands same sign and result sign differs.
  - SUB: unsigned = borrow (A < B unsigned); signed = operand signs differ and result sign ≠ A sign.
  - OR/AND: both overflows 0.
- Flags register loads all four ALU flags when flags_reg_enable=1; otherwise holds.
- PC: if pc_enable, PC ← branch ? IR address field : PC+1. PC+1 wraps 2^ADDR_W-1 → 0.

## Timing
- Reset (rst_n=0 at an edge) overrides all enables. PC=0, IR=0 (decodes I_NOP), all registers 0, all flags 0; hence ram_addr=0 and data_out=0.
- Reset asserted mid-instruction discards that instruction; no partial write survives.
- IR, PC, register file and flags update one edge after their strobe. decoded_instruction, ram_addr, data_out and ALU result are combinational from registered state.
- No write bypass: a register written at edge n appears on bus_a/bus_b after edge n.
- ir_enable and pc_enable together: both update; a branch uses the IR value held before that edge.
- write_reg_enable and flags_reg_enable together: both update; flags reflect the ALU result regardless of c_sel.

## Structure
- k_and_s_pkg holds decoded_instruction_type, the opcode constants, and the ALU op encoding constants.
- Sub-module ks_alu (parameter DATA_W) is combinational: operation, a, b → result and four raw flags. Flag registering stays in ks_data_path_p.

## Test plan
All scenarios use DATA_W=16, ADDR_W=5, NREGS=4.
- Reset: rst_n low for 2 edges with every enable high → PC=0, all flags 0, decoded_instruction=I_NOP, ram_addr=0, data_out=0.
- LOAD: IR←0x8145, addr_sel=1 → ram_addr=5, I_LOAD. Then data_in=0x1234, c_sel=1, write_reg_enable=1 → r2=0x1234.
- ADD overflow: r0=0x7FFF, r1=0x0001, IR=0xA134, operation=01, write+flags enabled → r3=0x8000; zero=0, neg=1, unsigned=0, signed=1.
- SUB borrow: r0=0, r1=1, IR=0xA234, operation=10 → r3=0xFFFF; neg=1, unsigned=1, signed=0, zero=0. With r0=r1=5 → zero=1, all others 0.
- PC: PC=31, pc_enable=1, branch=0 → PC=0. Then IR=0x0107, branch=1 → PC=7, decoded_instruction=I_BRANCH.
- Unknown opcode and flag hold: IR=0x55xx → I_NOP. An ALU op with flags_reg_enable=0 leaves flags at their prior values.
